// File: rtl/core_pkg.sv
// Shared types and default geometry for the data cache.
package core_pkg;

  // log2 of 32-bit words per line, and log2 of lines (direct-mapped)
  localparam int unsigned DCACHE_LINE_ADDR_LEN = 3;
  localparam int unsigned DCACHE_SET_ADDR_LEN  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    DONE      = 2'd3
  } dcache_state_e;

endpackage

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM and beat counter: optional victim write-back, line
// refill, then one DONE cycle before the held request is replayed as a hit.
module dcache_ctrl
  import core_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = DCACHE_LINE_ADDR_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_miss,          // req_i && !hit
  input  logic                     i_victim_dirty,  // valid && dirty at the addressed set
  input  logic                     i_mem_ready,
  output dcache_state_e            o_state,
  output logic [LINE_ADDR_LEN-1:0] o_cnt,
  output logic                     o_start,         // leaving IDLE: latch the miss address
  output logic                     o_fill_we,       // refill beat lands this cycle
  output logic                     o_fill_last      // final refill beat lands this cycle
);

  localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = '1;

  dcache_state_e            r_state;
  logic [LINE_ADDR_LEN-1:0] r_cnt;
  logic                     w_last;

  assign w_last      = (r_cnt == CNT_LAST);
  assign o_state     = r_state;
  assign o_cnt       = r_cnt;
  assign o_start     = (r_state == IDLE) && i_miss;
  assign o_fill_we   = (r_state == REFILL) && i_mem_ready;
  assign o_fill_last = o_fill_we && w_last;

  // State and beat counter; the counter only moves on accepted beats so the
  // memory address stays stable while the memory stalls.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would make r_state/r_cnt order-dependent in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_miss) begin
            r_state <= i_victim_dirty ? WRITEBACK : REFILL;
            r_cnt   <= '0;
          end
        end
        WRITEBACK: begin
          if (i_mem_ready) begin
            r_cnt <= r_cnt + 1'b1;  // wraps to 0 for the refill
            if (w_last) r_state <= REFILL;
          end
        end
        REFILL: begin
          if (i_mem_ready) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache with zero-latency hits and a
// word-serial memory port; miss sequencing lives in dcache_ctrl.
module dcache
  import core_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = DCACHE_LINE_ADDR_LEN,
  parameter int unsigned SET_ADDR_LEN  = DCACHE_SET_ADDR_LEN,
  parameter int unsigned DEBUG         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        miss_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned LINE_WORDS = 1 << LINE_ADDR_LEN;
  localparam int unsigned SETS       = 1 << SET_ADDR_LEN;
  localparam int unsigned SET_LSB    = LINE_ADDR_LEN + 2;
  localparam int unsigned TAG_LSB    = SET_ADDR_LEN + LINE_ADDR_LEN + 2;
  localparam int unsigned TAG_LEN    = 32 - TAG_LSB;

  logic [SETS-1:0]          r_valid;
  logic [SETS-1:0]          r_dirty;
  logic [TAG_LEN-1:0]       r_tag  [SETS];
  logic [31:0]              r_data [SETS][LINE_WORDS];
  logic [TAG_LEN-1:0]       r_miss_tag;
  logic [SET_ADDR_LEN-1:0]  r_miss_set;

  logic [TAG_LEN-1:0]       w_tag;
  logic [SET_ADDR_LEN-1:0]  w_set;
  logic [LINE_ADDR_LEN-1:0] w_word;
  logic [LINE_ADDR_LEN-1:0] w_cnt;
  dcache_state_e            w_state;
  logic                     w_hit;
  logic                     w_store;
  logic                     w_start;
  logic                     w_fill_we;
  logic                     w_fill_last;

  assign w_tag  = addr_i[31:TAG_LSB];
  assign w_set  = addr_i[TAG_LSB-1:SET_LSB];
  assign w_word = addr_i[SET_LSB-1:2];

  assign w_hit   = req_i && (w_state == IDLE) && r_valid[w_set] && (r_tag[w_set] == w_tag);
  assign w_store = w_hit && we_i;
  assign miss_o  = req_i && !w_hit;
  assign rdata_o = (w_hit && !we_i) ? r_data[w_set][w_word] : 32'h0;

  dcache_ctrl #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_miss        (miss_o),
    .i_victim_dirty(r_valid[w_set] && r_dirty[w_set]),
    .i_mem_ready   (mem_ready_i),
    .o_state       (w_state),
    .o_cnt         (w_cnt),
    .o_start       (w_start),
    .o_fill_we     (w_fill_we),
    .o_fill_last   (w_fill_last)
  );

  // Memory port: driven only while transferring, always from the latched set
  // so a core that drops or changes its request cannot disturb the sequence.
  // NOTE: every output gets a default before the case; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    unique case (w_state)
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {r_tag[r_miss_set], r_miss_set, w_cnt, 2'b00};
        mem_wdata_o = r_data[r_miss_set][w_cnt];
      end
      REFILL: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = {r_miss_tag, r_miss_set, w_cnt, 2'b00};
      end
      default: ;
    endcase
  end

  // Line state bits: set valid/clean when a fill completes, dirty on store hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill_last) begin
      r_valid[r_miss_set] <= 1'b1;
      r_dirty[r_miss_set] <= 1'b0;
    end else if (w_store) begin
      r_dirty[w_set] <= 1'b1;
    end
  end

  // Capture tag and set of the missing access as the FSM leaves IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_tag <= '0;
      r_miss_set <= '0;
    end else if (w_start) begin
      r_miss_tag <= w_tag;
      r_miss_set <= w_set;
    end
  end

  // Tag and data arrays: refill beats and byte-masked store hits.
  // NOTE: no reset on the arrays; contents are qualified by r_valid, so
  // clearing them would only add reset fan-out and block RAM mapping.
  always_ff @(posedge clk) begin
    if (w_fill_we) r_data[r_miss_set][w_cnt] <= mem_rdata_i;
    if (w_fill_last) r_tag[r_miss_set] <= r_miss_tag;
    if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) r_data[w_set][w_word][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Debug hooks: interface sanity checks, no effect on function.
  if (DEBUG != 0) begin : g_debug
    always @(posedge clk) begin
      if (rst_n) begin
        assert (!mem_we_o || mem_req_o);
        assert (!req_i || addr_i[1:0] == 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: a behavioural memory with programmable
// ready latency, an expected-beat scoreboard and expected load data.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        miss_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  dcache #(
    .LINE_ADDR_LEN(3),
    .SET_ADDR_LEN (4),
    .DEBUG        (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .miss_o     (miss_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          lat      = 0;
  int          wait_cnt = 0;
  int          beats    = 0;
  logic [31:0] hold_addr, hold_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'hD000_0000 | a;
  endfunction

  task automatic push_reads(input logic [31:0] base);
    for (int i = 0; i < 8; i++) exp_q.push_back('{1'b0, base + 32'(4 * i), 32'h0});
  endtask

  // Memory model: decides ready on the falling edge, checks each accepted
  // beat against the scoreboard and holds address/data checks while stalled.
  always @(negedge clk) begin
    beat_t e;
    mem_ready_i = 1'b0;
    if (mem_req_o) begin
      if (wait_cnt == 0) begin
        hold_addr = mem_addr_o;
        hold_data = mem_wdata_o;
      end else begin
        check("stall_addr_stable", mem_addr_o, hold_addr);
        check("stall_wdata_stable", mem_wdata_o, hold_data);
      end
      if (wait_cnt == lat) begin
        mem_ready_i = 1'b1;
        wait_cnt    = 0;
        beats++;
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_we", 32'(mem_we_o), 32'(e.we));
          check("beat_addr", mem_addr_o, e.addr);
          if (e.we) check("beat_wdata", mem_wdata_o, e.data);
        end
        if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
        else          mem_rdata_i = rd(mem_addr_o);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // One core access held until miss_o drops; load data is checked the cycle it hits.
  task automatic access(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_miss, input logic [31:0] exp_rdata);
    int          cyc;
    logic [31:0] exp;
    if (!we) rd_q.push_back(exp_rdata);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    #1;
    check({tag, "_miss"}, 32'(miss_o), 32'(exp_miss));
    cyc = 0;
    while (miss_o && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_served"}, 32'(miss_o), 32'd0);
    if (!we) begin
      exp = rd_q.pop_front();
      check({tag, "_rdata"}, rdata_o, exp);
    end
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    check({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, cyc;
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    for (int i = 0; i < 8; i++) mem_model[32'h40 + 32'(4 * i)] = 32'h1000 + 32'(i);
    mem_model[32'h48] = 32'h1122_3344;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_miss", 32'(miss_o), 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    req_i = 1'b1; addr_i = 32'h40; #1;
    check("rst_miss_follows_req", 32'(miss_o), 32'd1);
    req_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Scenario 1: cold load, then a reload of the same line with no traffic
    push_reads(32'h40); b0 = beats;
    access("s1_load", 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'h0000_1000);
    check("s1_refill_beats", 32'(beats - b0), 32'd8);
    b0 = beats;
    access("s1_reload", 1'b0, 4'h0, 32'h44, 32'h0, 1'b0, 32'h0000_1001);
    check("s1_reload_beats", 32'(beats - b0), 32'd0);

    // Scenario 2: byte-masked store hit, then load
    b0 = beats;
    access("s2_store", 1'b1, 4'b0011, 32'h48, 32'hAABB_CCDD, 1'b0, 32'h0);
    access("s2_load", 1'b0, 4'h0, 32'h48, 32'h0, 1'b0, 32'h1122_CCDD);
    check("s2_beats", 32'(beats - b0), 32'd0);

    // Scenario 3: dirty set 2 evicted by a conflicting tag, then read back
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{1'b1, 32'h40 + 32'(4 * i), (i == 2) ? 32'h1122_CCDD : 32'h1000 + 32'(i)});
    push_reads(32'h240); b0 = beats;
    access("s3_conflict", 1'b0, 4'h0, 32'h244, 32'h0, 1'b1, rd(32'h244));
    check("s3_beats", 32'(beats - b0), 32'd16);
    push_reads(32'h40);
    access("s3_roundtrip", 1'b0, 4'h0, 32'h48, 32'h0, 1'b1, 32'h1122_CCDD);

    // Scenario 4: 5-cycle ready stall on refill and write-back
    lat = 5;
    push_reads(32'h300);
    access("s4_fill", 1'b0, 4'h0, 32'h31C, 32'h0, 1'b1, rd(32'h31C));
    access("s4_store", 1'b1, 4'hF, 32'h300, 32'h5555_AAAA, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{1'b1, 32'h300 + 32'(4 * i), (i == 0) ? 32'h5555_AAAA : rd(32'h300 + 32'(4 * i))});
    push_reads(32'h700);
    access("s4_evict", 1'b0, 4'h0, 32'h704, 32'h0, 1'b1, rd(32'h704));
    check("s4_wb_mem", rd(32'h300), 32'h5555_AAAA);
    lat = 0;

    // Scenario 5: reset at refill beat 4, then the same address misses again
    push_reads(32'hA0); b0 = beats;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'hA0;
    cyc = 0;
    while (beats - b0 < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("s5_beat4_reached", 32'(beats - b0), 32'd4);
    rst_n = 1'b0; #1;
    check("s5_rst_mem_req", 32'(mem_req_o), 32'd0);
    check("s5_rst_miss", 32'(miss_o), 32'd1);
    exp_q.delete();
    req_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    push_reads(32'hA0);
    access("s5_reaccess", 1'b0, 4'h0, 32'hA0, 32'h0, 1'b1, rd(32'hA0));

    // Scenario 6: request dropped at beat 3, fill still completes
    push_reads(32'hC0); b0 = beats;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'hC0;
    cyc = 0;
    while (beats - b0 < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    req_i = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("s6_fill_complete", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    b0 = beats;
    access("s6_hit", 1'b0, 4'h0, 32'hC8, 32'h0, 1'b0, rd(32'hC8));
    check("s6_hit_beats", 32'(beats - b0), 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
